jmb_scanline_filter_p: RTL
==========================

JMB_SCANLINE_FILTER_P -- requirements
Module: jmb_scanline_filter_p

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width (unsigned).
REQ-002 SHALL have parameter COEF_W, default 8, width of each signed two's-complement coefficient.
REQ-003 SHALL have parameter HALF, default 2, taps per side (filter length 2*HALF+1); legal range 1..4.
REQ-004 SHALL have parameter SHIFT_W, default 4, width of the normalisation shift.
REQ-005 SHALL have port clock, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port enable, input, 1: 0 stalls the input side and flush.
REQ-008 SHALL have port in_valid, input, 1: input pixel valid.
REQ-009 SHALL have port in_data, input, PIX_W: input pixel.
REQ-010 SHALL have port in_sol, input, 1: first pixel of line.
REQ-011 SHALL have port in_eol, input, 1: last pixel of line.
REQ-012 SHALL have port in_ready, output, 1: input accept; transfer = in_valid & in_ready.
REQ-013 SHALL have port mode, input, 1: 0 bypass, 1 filter.
REQ-014 SHALL have port coeff, input, (HALF+1)*COEF_W: packed coefficients; slice j = c[j], c[0] is centre.
REQ-015 SHALL have port shift, input, SHIFT_W: right-shift amount.
REQ-016 SHALL have port out_valid, output, 1: output pixel valid.
REQ-017 SHALL have port out_data, output, PIX_W: output pixel.
REQ-018 SHALL have port out_eol, output, 1: marks the last output of a line.
REQ-019 SHALL have port out_ready, input, 1: downstream accept.
REQ-020 SHALL have port line_err, output, 1: one-cycle protocol-error pulse.

Function
REQ-021 SHALL keep window w[0..2*HALF], newest at w[2*HALF], centre w[HALF].
REQ-022 SHALL implement FSM states IDLE, PRIME, RUN, FLUSH.
REQ-023 SHALL define stall = out_valid & !out_ready.
REQ-024 SHALL drive in_ready = enable & !stall & state!=FLUSH.
REQ-025 SHALL, in IDLE, on an accepted pixel with in_sol: load all window cells with in_data, latch mode/coeff/shift for the line, and set cnt=0.
REQ-026 SHALL, on IDLE accept with in_sol, go to FLUSH if in_eol is set, else PRIME.
REQ-027 SHALL, in IDLE, accept and drop a pixel without in_sol, and pulse line_err.
REQ-028 SHALL, in PRIME/RUN, shift in each accepted pixel and increment cnt (saturating at HALF).
REQ-029 SHALL produce an output on a PRIME/RUN shift when cnt (before increment) >= HALF-1; the centre pixel is then the pixel accepted HALF transfers earlier.
REQ-030 SHALL track pending = number of accepted pixels of the line not yet output (0..HALF).
REQ-031 SHALL go to FLUSH on acceptance of in_eol; when pending=0, IDLE instead.
REQ-032 SHALL, in FLUSH, shift in a copy of w[2*HALF] once per cycle with enable & !stall, emitting one output per shift until pending=0, then return to IDLE.
REQ-033 SHALL set out_eol on the final output of a line.
REQ-034 SHALL, on in_sol accepted in PRIME/RUN: pulse line_err, discard pending outputs, and restart the line per REQ-025.
REQ-035 SHALL emit exactly N outputs, in order, for each well-formed line of N>=1 pixels.
REQ-036 SHALL register out_data/out_valid/out_eol on the producing shift (latency 1 cycle after the shift).
REQ-037 SHALL clear out_valid when out_ready=1 and no new output is produced.
REQ-038 SHALL hold out_data/out_valid/out_eol while stall=1; the output side drains regardless of enable.
REQ-039 SHALL, in bypass mode, output out_data = w[HALF] unchanged.
REQ-040 SHALL compute filter acc = c[0]*w[HALF] + sum over j=1..HALF of c[j]*(w[HALF-j]+w[HALF+j]), signed, full precision with no overflow.
REQ-041 SHALL compute res = (acc + (shift>0 ? 2^(shift-1) : 0)) arithmetically shifted right by shift.
REQ-042 SHALL output out_data = 0 if res<0, 2^PIX_W-1 if res > 2^PIX_W-1, else res.
REQ-043 SHALL ignore changes to mode/coeff/shift until the next accepted in_sol.

Reset
REQ-044 SHALL, while reset=1, set state IDLE, window/cnt/pending 0, out_valid 0, out_data 0, out_eol 0, line_err 0, in_ready 0; reset overrides enable and may occur mid-line (line abandoned, no output).

Verification
REQ-045 SHALL pass: bypass, line 10,20,30,40,50 -> out 10,20,30,40,50, out_eol only with 50.
REQ-046 SHALL pass: filter, HALF=2, c=(2,1,0), shift 2, line 0,0,100,0,0 -> out 0,25,50,25,0.
REQ-047 SHALL pass: c=(1,-1,0), shift 0, line 0,200,0 -> 0,200,0; c=(4,0,0), shift 0, constant 100 -> all 255.
REQ-048 SHALL pass: single pixel with in_sol=in_eol=1, value 77, c=(2,1,0), shift 2 -> one output 77 with out_eol.
REQ-049 SHALL pass: out_ready low 3 cycles mid-line -> out_data held, in_ready 0, no loss/reorder, 5-in/5-out preserved.
REQ-050 SHALL pass: in_sol after 3 pixels without eol -> line_err 1 cycle, stale outputs dropped, next line correct; reset mid-FLUSH -> all outputs 0 next cycle.

Source files
------------

// File: rtl/jmb_scanline_filter_p.sv
// Scanline FIR filter: symmetric (2*HALF+1)-tap filter over a pixel stream,
// with edge replication at both ends of each line, per-line latched settings,
// a rounding/normalising shift and clamping to the pixel range.
module jmb_scanline_filter_p #(
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int HALF    = 2,
  parameter int SHIFT_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [PIX_W-1:0]           in_data,
  input  logic                       in_sol,
  input  logic                       in_eol,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic [(HALF+1)*COEF_W-1:0] coeff,
  input  logic [SHIFT_W-1:0]         shift,
  output logic                       out_valid,
  output logic [PIX_W-1:0]           out_data,
  output logic                       out_eol,
  input  logic                       out_ready,
  output logic                       line_err
);

  localparam int NW    = 2 * HALF + 1;
  localparam int CW    = 3;                  // holds 0..HALF for HALF <= 4
  localparam int ACC_W = PIX_W + COEF_W + 5; // sign + pair-sum + 5-term growth
  localparam int SW    = ACC_W + 1;          // room for the rounding bias
  localparam logic signed [SW-1:0] PIX_MAX = {{(SW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  state_t                     state_r, state_s;
  logic [PIX_W-1:0]           win_r [0:NW-1];
  logic [PIX_W-1:0]           win_s [0:NW-1];
  logic [CW-1:0]              cnt_r, cnt_s;
  logic [CW-1:0]              pend_r, pend_s;
  logic                       mode_r;
  logic [(HALF+1)*COEF_W-1:0] coef_r;
  logic [SHIFT_W-1:0]         shift_r;

  logic                       out_valid_r;
  logic [PIX_W-1:0]           out_data_r;
  logic                       out_eol_r;
  logic                       line_err_r;

  logic                       stall_s, in_ready_s, accept_s;
  logic                       load_s, shift_en_s, produce_s, last_s, err_s;
  logic [PIX_W-1:0]           shift_in_s;
  logic [PIX_W-1:0]           pix_s;

  logic signed [ACC_W-1:0]    acc_s, c_s, p_s;
  logic signed [SW-1:0]       bias_s, sum_s, res_s;
  logic [31:0]                sh_v;

  assign stall_s    = out_valid_r & ~out_ready;
  assign in_ready_s = enable & ~stall_s & (state_r != FLUSH) & ~reset;
  assign accept_s   = in_valid & in_ready_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_eol   = out_eol_r;
  assign line_err  = line_err_r;

  // Line sequencing: decides load/shift/produce and the next state, count and pending.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    pend_s     = pend_r;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    shift_in_s = in_data;
    produce_s  = 1'b0;
    last_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (in_sol) begin
            load_s  = 1'b1;
            cnt_s   = CW'(0);
            pend_s  = CW'(1);
            state_s = in_eol ? FLUSH : PRIME;
          end else begin
            err_s = 1'b1;   // stray pixel outside a line is dropped
          end
        end else begin
          state_s = IDLE;
        end
      end
      PRIME, RUN: begin
        if (accept_s) begin
          if (in_sol) begin
            // Restart: pending outputs of the broken line are abandoned.
            err_s   = 1'b1;
            load_s  = 1'b1;
            cnt_s   = CW'(0);
            pend_s  = CW'(1);
            state_s = in_eol ? FLUSH : PRIME;
          end else begin
            shift_en_s = 1'b1;
            produce_s  = (cnt_r >= CW'(HALF - 1));
            cnt_s      = (cnt_r == CW'(HALF)) ? cnt_r : cnt_r + CW'(1);
            pend_s     = produce_s ? pend_r : pend_r + CW'(1);
            if (in_eol) begin
              if (pend_s == CW'(0)) begin
                state_s = IDLE;
                last_s  = produce_s;
              end else begin
                state_s = FLUSH;
              end
            end else begin
              state_s = (cnt_s == CW'(HALF)) ? RUN : PRIME;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      FLUSH: begin
        if (pend_r == CW'(0)) begin
          state_s = IDLE;
        end else if (enable & ~stall_s) begin
          // Replicate the last pixel to complete the right-hand edge.
          shift_en_s = 1'b1;
          shift_in_s = win_r[NW-1];
          produce_s  = 1'b1;
          pend_s     = pend_r - CW'(1);
          if (pend_s == CW'(0)) begin
            last_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = FLUSH;
          end
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next window contents: line start replicates the first pixel into every cell.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      win_s[i] = win_r[i];
    end
    if (load_s) begin
      for (int i = 0; i < NW; i++) begin
        win_s[i] = in_data;
      end
    end else if (shift_en_s) begin
      for (int i = 0; i < NW - 1; i++) begin
        win_s[i] = win_r[i+1];
      end
      win_s[NW-1] = shift_in_s;
    end else begin
      win_s[NW-1] = win_r[NW-1];
    end
  end

  // Filter datapath on the post-shift window: symmetric MAC, rounding shift, clamp.
  always_comb begin
    c_s   = ACC_W'($signed(coef_r[COEF_W-1:0]));
    p_s   = ACC_W'({1'b0, win_s[HALF]});
    acc_s = c_s * p_s;
    for (int j = 1; j <= HALF; j++) begin
      c_s   = ACC_W'($signed(coef_r[j*COEF_W +: COEF_W]));
      p_s   = ACC_W'({1'b0, win_s[HALF-j]}) + ACC_W'({1'b0, win_s[HALF+j]});
      acc_s = acc_s + c_s * p_s;
    end
    sh_v = 32'(shift_r);
    // A bias beyond the accumulator range cannot change the clamped result.
    if ((sh_v != 32'd0) && (sh_v <= 32'(ACC_W))) begin
      bias_s = {{(SW-1){1'b0}}, 1'b1} << (sh_v - 32'd1);
    end else begin
      bias_s = {SW{1'b0}};
    end
    sum_s = SW'(acc_s) + bias_s;
    res_s = sum_s >>> shift_r;
    if (!mode_r) begin
      pix_s = win_s[HALF];
    end else if (res_s[SW-1]) begin
      pix_s = {PIX_W{1'b0}};
    end else if (res_s > PIX_MAX) begin
      pix_s = {PIX_W{1'b1}};
    end else begin
      pix_s = res_s[PIX_W-1:0];
    end
  end

  // Line state registers: FSM, window, counters and per-line settings.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CW'(0);
      pend_r  <= CW'(0);
      mode_r  <= 1'b0;
      coef_r  <= {((HALF+1)*COEF_W){1'b0}};
      shift_r <= {SHIFT_W{1'b0}};
      for (int i = 0; i < NW; i++) begin
        win_r[i] <= {PIX_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      for (int i = 0; i < NW; i++) begin
        win_r[i] <= win_s[i];
      end
      if (load_s) begin
        mode_r  <= mode;
        coef_r  <= coeff;
        shift_r <= shift;
      end
    end
  end

  // Output register: load on a producing shift, drain on out_ready, hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {PIX_W{1'b0}};
      out_eol_r   <= 1'b0;
      line_err_r  <= 1'b0;
    end else begin
      line_err_r <= err_s;
      if (produce_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= pix_s;
        out_eol_r   <= last_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
        out_eol_r   <= 1'b0;
      end
    end
  end

endmodule
